// File: rtl/nanci_pkg.sv
// Shared definitions for the Nanci edge collector.
//   collect_state_e : collector FSM states (IDLE, WAIT, DRAIN, DONE)
//   word_width()    : PE word width, W = ADDR_WIDTH + DATA_WIDTH
//   idx_width()     : row-index width, clog2(SQRT_N) but never below 1
package nanci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } collect_state_e;

  function automatic int word_width(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nanci_edge_collector_buffer.sv
// nanci_word_buffer: N x W register array holding one snapshot of the mesh edge.
// Ports:
//   clk       : clock
//   load_i    : parallel load of all N rows from data_i
//   data_i    : concatenated rows, row r at [r*W +: W]
//   rd_idx_i  : read row index
//   rd_word_o : selected row (zero when rd_idx_i >= N)
// No reset: contents are only meaningful after a load.
module nanci_word_buffer #(
  parameter int W  = 6,
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            load_i,
  input  logic [N*W-1:0]  data_i,
  input  logic [IW-1:0]   rd_idx_i,
  output logic [W-1:0]    rd_word_o
);

  logic [W-1:0] mem_q [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_row
      always_ff @(posedge clk) begin
        if (load_i) begin
          mem_q[gi] <= data_i[gi*W +: W];
        end
      end
    end
  endgenerate

  // Compare-and-select mux keeps out-of-range indices (non power-of-two N,
  // or idx+1 past the last row) harmless: they read as zero.
  always_comb begin
    rd_word_o = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_idx_i == IW'(i)) begin
        rd_word_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/nanci_edge_collector.sv
// nanci_edge_collector: drains the right-hand column of the Nanci sorting mesh.
// After a start pulse it waits SORT_CYCLES cycles, snapshots every edge PE word
// at once, then streams them out row 0 first over valid/ready.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   i_start   : start pulse, only honoured in IDLE
//   i_PE      : concatenated edge-PE words, row r at [r*W +: W]
//   o_word    : current word {addr,data}, registered
//   o_valid   : o_word valid, registered
//   i_ready   : consumer accepts o_word when o_valid is high
//   o_busy    : high in every state except IDLE
//   o_done    : one-cycle pulse after the last word is accepted
//   o_parity  : XOR of o_word, only when NANCI_COLLECT_PARITY_EN is defined
module nanci_edge_collector
  import nanci_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 3,
  parameter int SQRT_N      = 4,
  parameter int SORT_CYCLES = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_start,
  input  logic [SQRT_N*(ADDR_WIDTH+DATA_WIDTH)-1:0] i_PE,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0]          o_word,
  output logic                                      o_valid,
  input  logic                                      i_ready,
  output logic                                      o_busy,
  output logic                                      o_done
`ifdef NANCI_COLLECT_PARITY_EN
  ,
  output logic                                      o_parity
`endif
);

  localparam int W  = word_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int IW = idx_width(SQRT_N);
  localparam int CW = idx_width(SORT_CYCLES);

  collect_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   word_q, word_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           buf_load;
  logic [IW-1:0]  rd_idx;
  logic [W-1:0]   rd_word;

  // The buffer is read one row ahead so the next word can be registered
  // into word_q on the same edge that accepts the current one.
  assign rd_idx = idx_q + IW'(1);

  nanci_word_buffer #(
    .W  (W),
    .N  (SQRT_N),
    .IW (IW)
  ) u_buf (
    .clk       (clk),
    .load_i    (buf_load),
    .data_i    (i_PE),
    .rd_idx_i  (rd_idx),
    .rd_word_o (rd_word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    word_d   = word_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    buf_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_WAIT;
          cnt_d   = CW'(SORT_CYCLES - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          // Capture edge: row 0 goes straight to the output register,
          // the whole column is latched into the buffer.
          buf_load = 1'b1;
          idx_d    = '0;
          word_d   = i_PE[W-1:0];
          valid_d  = 1'b1;
          state_d  = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRAIN: begin
        if (i_ready) begin
          if (idx_q == IW'(SQRT_N - 1)) begin
            valid_d = 1'b0;
            word_d  = '0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d  = rd_idx;
            word_d = rd_word;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_word  = word_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

`ifdef NANCI_COLLECT_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^word_d;
    end
  end

  assign o_parity = parity_q;
`endif

endmodule

// File: tb/tb_nanci_edge_collector.sv
module tb_nanci_edge_collector;

  localparam int AW = 3;
  localparam int DW = 3;
  localparam int SN = 2;
  localparam int SC = 2;
  localparam int W  = AW + DW;

  logic            clk;
  logic            rst;
  logic            i_start;
  logic [SN*W-1:0] i_PE;
  logic [W-1:0]    o_word;
  logic            o_valid;
  logic            i_ready;
  logic            o_busy;
  logic            o_done;
`ifdef NANCI_COLLECT_PARITY_EN
  logic            o_parity;
`endif

  nanci_edge_collector #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .SQRT_N      (SN),
    .SORT_CYCLES (SC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_PE    (i_PE),
    .o_word  (o_word),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_busy  (o_busy),
    .o_done  (o_done)
`ifdef NANCI_COLLECT_PARITY_EN
    ,
    .o_parity(o_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic            start;
    logic            ready;
    logic [SN*W-1:0] pe;
    logic            e_valid;
    logic [W-1:0]    e_word;
    logic            e_busy;
    logic            e_done;
    logic            chk_word;
  } vec_t;

  vec_t vecs[$];
  int checks;
  int errors;

  localparam logic [SN*W-1:0] P1 = 12'b010011_000101;
  localparam logic [SN*W-1:0] P2 = 12'b111111_111111;
  localparam logic [SN*W-1:0] P3 = 12'b101110_011001;
  localparam logic [SN*W-1:0] P4 = 12'b110001_001110;

  function automatic void add(input logic r, input logic s, input logic rd,
                              input logic [SN*W-1:0] pe, input logic ev,
                              input logic [W-1:0] ew, input logic eb,
                              input logic ed, input logic cw);
    vec_t v;
    v.rst = r; v.start = s; v.ready = rd; v.pe = pe;
    v.e_valid = ev; v.e_word = ew; v.e_busy = eb; v.e_done = ed; v.chk_word = cw;
    vecs.push_back(v);
  endfunction

  task automatic check1(input string name, input int step, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
    end
  endtask

  logic [W-1:0] got_words[$];
  int done_cnt;
  int budget;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; i_start = 1'b0; i_ready = 1'b0; i_PE = P1;

    // rst start ready pe    valid word      busy done chkw
    add(1, 0, 0, P1, 0, 6'b000000, 0, 0, 1);
    add(1, 0, 0, P1, 0, 6'b000000, 0, 0, 1);
    add(0, 0, 0, P1, 0, 6'b000000, 0, 0, 1);
    // basic collection, ready held high
    add(0, 1, 1, P1, 0, 6'b000000, 1, 0, 1);
    add(0, 0, 1, P1, 0, 6'b000000, 1, 0, 1);
    add(0, 0, 1, P1, 1, 6'b000101, 1, 0, 1);
    add(0, 0, 1, P1, 1, 6'b010011, 1, 0, 1);
    add(0, 0, 1, P1, 0, 6'b000000, 1, 1, 0);
    add(0, 0, 1, P1, 0, 6'b000000, 0, 0, 0);
    // backpressure, with i_PE changing after capture
    add(0, 1, 0, P1, 0, 6'b000000, 1, 0, 0);
    add(0, 0, 0, P1, 0, 6'b000000, 1, 0, 0);
    add(0, 0, 0, P1, 1, 6'b000101, 1, 0, 1);
    add(0, 0, 0, P2, 1, 6'b000101, 1, 0, 1);
    add(0, 0, 0, P2, 1, 6'b000101, 1, 0, 1);
    add(0, 0, 0, P2, 1, 6'b000101, 1, 0, 1);
    add(0, 0, 1, P2, 1, 6'b010011, 1, 0, 1);
    add(0, 0, 1, P2, 0, 6'b000000, 1, 1, 0);
    add(0, 0, 0, P2, 0, 6'b000000, 0, 0, 0);
    // start repeated during WAIT, DRAIN and DONE is ignored
    add(0, 1, 1, P1, 0, 6'b000000, 1, 0, 0);
    add(0, 1, 1, P1, 0, 6'b000000, 1, 0, 0);
    add(0, 1, 1, P1, 1, 6'b000101, 1, 0, 1);
    add(0, 1, 1, P1, 1, 6'b010011, 1, 0, 1);
    add(0, 1, 1, P1, 0, 6'b000000, 1, 1, 0);
    add(0, 1, 1, P1, 0, 6'b000000, 0, 0, 0);
    add(0, 0, 1, P1, 0, 6'b000000, 0, 0, 0);
    add(0, 0, 1, P1, 0, 6'b000000, 0, 0, 0);
    // reset mid-DRAIN, then a fresh collection
    add(0, 1, 0, P1, 0, 6'b000000, 1, 0, 0);
    add(0, 0, 0, P1, 0, 6'b000000, 1, 0, 0);
    add(0, 0, 0, P1, 1, 6'b000101, 1, 0, 1);
    add(1, 0, 0, P1, 0, 6'b000000, 0, 0, 1);
    add(0, 0, 1, P3, 0, 6'b000000, 0, 0, 1);
    add(0, 1, 1, P3, 0, 6'b000000, 1, 0, 1);
    add(0, 0, 1, P3, 0, 6'b000000, 1, 0, 1);
    add(0, 0, 1, P3, 1, 6'b011001, 1, 0, 1);
    add(0, 0, 1, P3, 1, 6'b101110, 1, 0, 1);
    add(0, 0, 1, P3, 0, 6'b000000, 1, 1, 0);
    add(0, 0, 1, P3, 0, 6'b000000, 0, 0, 0);

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst     = vecs[i].rst;
      i_start = vecs[i].start;
      i_ready = vecs[i].ready;
      i_PE    = vecs[i].pe;
      @(posedge clk);
      #1;
      $display("step %0d rst=%b start=%b ready=%b -> valid=%b word=%b busy=%b done=%b",
               i, rst, i_start, i_ready, o_valid, o_word, o_busy, o_done);
      check1("o_valid", i, W'(o_valid), W'(vecs[i].e_valid));
      check1("o_busy",  i, W'(o_busy),  W'(vecs[i].e_busy));
      check1("o_done",  i, W'(o_done),  W'(vecs[i].e_done));
      if (vecs[i].chk_word) begin
        check1("o_word", i, o_word, vecs[i].e_word);
`ifdef NANCI_COLLECT_PARITY_EN
        check1("o_parity", i, W'(o_parity), W'(^vecs[i].e_word));
`endif
      end
    end

    // Toggling-ready drain collected through a scoreboard.
    i_PE = P4; i_ready = 1'b0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    done_cnt = 0;
    budget = 0;
    while ((o_busy || done_cnt == 0) && budget < 40) begin
      i_ready = budget[0];
      if (o_valid && i_ready) got_words.push_back(o_word);
      @(posedge clk); #1;
      if (o_done) done_cnt++;
      budget++;
    end
    $display("toggle drain: %0d words, %0d done pulses, %0d cycles",
             got_words.size(), done_cnt, budget);
    checks++;
    if (budget >= 40) begin
      errors++;
      $display("FAIL toggle_timeout: got %0d cycles required < 40", budget);
    end
    check1("toggle_count", 0, W'(got_words.size()), W'(2));
    check1("toggle_done",  0, W'(done_cnt), W'(1));
    if (got_words.size() == 2) begin
      check1("toggle_word0", 0, got_words[0], 6'b001110);
      check1("toggle_word1", 1, got_words[1], 6'b110001);
    end
    check1("toggle_busy_end", 0, W'(o_busy), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
